// File: rtl/uart_tx_word.sv
// uart_tx_word: serial output stage for the 16-bit datapath.
// Buffers 16-bit words in a small FIFO and sends each one as two UART frames,
// low byte first, with no gap between the two bytes of a word and exactly one
// idle cycle between consecutive words.
//
// Ports:
//   clk        system clock, rising edge
//   Rst        synchronous active-high reset; flushes FIFO, abandons any frame
//   UTX_Din    word to transmit, sampled when UTX_Wr is high and FIFO not full
//   UTX_Wr     write strobe, one word per cycle
//   UTX_Full   FIFO holds DEPTH words
//   UTX_Level  words in FIFO, not counting the word being shifted out
//   UTX_Ovf    sticky flag: a write was dropped because the FIFO was full
//   UTX_UBusy  low only when idle with an empty FIFO
//   UTX_SOut   serial line, idle high
module uart_tx_word #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                     clk,
  input  logic                     Rst,
  input  logic [15:0]              UTX_Din,
  input  logic                     UTX_Wr,
  output logic                     UTX_Full,
  output logic [$clog2(DEPTH):0]   UTX_Level,
  output logic                     UTX_Ovf,
  output logic                     UTX_UBusy,
  output logic                     UTX_SOut
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(STOP_BITS * CLKS_PER_BIT);

  localparam logic [AW:0]   DepthCnt   = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] BitReload  = CW'(CLKS_PER_BIT - 1);
  // The stop period is timed as one long interval covering all stop bits.
  localparam logic [CW-1:0] StopReload = CW'(STOP_BITS * CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  // FIFO storage and bookkeeping
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q;

  // Transmitter state
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          byte_sel_q, byte_sel_d;
  logic [15:0]   hold_q, hold_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [7:0]    tx_byte;

  // Full is judged on the pre-edge count, so a write on a pop edge while full
  // is still dropped.
  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);
  assign push  = UTX_Wr && !full;
  assign pop   = (state_q == StIdle) && !empty;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage has no reset; the count register alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= UTX_Din;
    end
  end

  // State register process
  always_ff @(posedge clk) begin
    if (Rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      byte_sel_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (UTX_Wr && full) begin
        ovf_q <= 1'b1;
      end
      count_q    <= count_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      byte_sel_q <= byte_sel_d;
      hold_q     <= hold_d;
    end
  end

  // Next-state process
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    byte_sel_d = byte_sel_q;
    hold_d     = hold_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          hold_d     = mem[rd_ptr_q];
          byte_sel_d = 1'b0;
          cnt_d      = BitReload;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          cnt_d   = BitReload;
          idx_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          if (idx_q == 3'd7) begin
            cnt_d   = StopReload;
            state_d = StStop;
          end else begin
            idx_d = idx_q + 3'd1;
            cnt_d = BitReload;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StStop: begin
        if (cnt_q == '0) begin
          if (!byte_sel_q) begin
            // High byte follows immediately, no idle gap inside a word.
            byte_sel_d = 1'b1;
            cnt_d      = BitReload;
            state_d    = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output process
  assign tx_byte = byte_sel_q ? hold_q[15:8] : hold_q[7:0];

  always_comb begin
    UTX_SOut = 1'b1;
    unique case (state_q)
      StIdle:  UTX_SOut = 1'b1;
      StStart: UTX_SOut = 1'b0;
      StData:  UTX_SOut = tx_byte[idx_q];
      StStop:  UTX_SOut = 1'b1;
      default: UTX_SOut = 1'b1;
    endcase
  end

  assign UTX_UBusy = (state_q != StIdle) || !empty;
  assign UTX_Full  = full;
  assign UTX_Level = count_q;
  assign UTX_Ovf   = ovf_q;

endmodule
